// File: rtl/bpsk_costas_loop.sv
// bpsk_costas_loop
//   Costas carrier-tracking loop for the BPSK receive path. Received samples
//   are mixed with the NCO cos/sin, integrated and dumped over one symbol
//   (2^lnd accepted samples), turned into a Costas phase error, filtered by
//   a PI loop filter and fed back to the NCO as a new phase increment.
//   Also produces the soft/hard symbol decision and a lock indication.
//
//   Pipeline (enabled cycles after the last accepted sample of a symbol):
//     +1 product registered, +2 dump / sym_valid, +3 error + lock state,
//     +4 phi_inc_o / phi_inc_valid.
//
//   Lock FSM
//     state | meaning
//     ACQ   | acquiring; run counts consecutive good dumps
//     TRACK | locked; run counts consecutive bad dumps
//
// Ports
//   clk, reset         system clock, asynchronous active-high reset
//   clken              clock enable; every register holds while low
//   din, din_valid     signed received sample and its qualifier
//   fsin_i, fcos_i     signed NCO sine / cosine
//   nco_valid          NCO output qualifier
//   phi_inc_o          phase increment to the NCO
//   phi_inc_valid      phi_inc_o updated strobe
//   i_sym              soft symbol (I dump scaled by 2^-lnd)
//   sym_bit            hard decision, 1 when I dump is negative
//   sym_valid          symbol strobe
//   locked             loop lock flag
module bpsk_costas_loop #(
  parameter int             dw       = 10,
  parameter int             mpr      = 10,
  parameter int             apr      = 32,
  parameter int             lnd      = 4,
  parameter int             kp_sh    = 6,
  parameter int             ki_sh    = 12,
  parameter logic [apr-1:0] phi_nom  = 32'h0800_0000,
  parameter int             intlim   = 1 << 24,
  parameter int             lock_cnt = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clken,
  input  logic signed [dw-1:0]     din,
  input  logic                     din_valid,
  input  logic signed [mpr-1:0]    fsin_i,
  input  logic signed [mpr-1:0]    fcos_i,
  input  logic                     nco_valid,
  output logic [apr-1:0]           phi_inc_o,
  output logic                     phi_inc_valid,
  output logic signed [dw+mpr-1:0] i_sym,
  output logic                     sym_bit,
  output logic                     sym_valid,
  output logic                     locked
);

  localparam int pw = dw + mpr;
  localparam int aw = pw + lnd;
  localparam int rw = $clog2(lock_cnt + 1);
  localparam logic signed [apr:0] lim_pos = (apr+1)'(intlim);
  localparam logic signed [apr:0] lim_neg = -lim_pos;

  // ---------------- stage 1: mixer ----------------
  logic                 accept;
  logic [lnd-1:0]       cnt;
  logic signed [pw-1:0] mul_i, mul_q, prod_i, prod_q;
  logic                 prod_vld, prod_last;

  assign accept = din_valid & nco_valid;
  assign mul_i  = pw'(din) * pw'(fcos_i);
  assign mul_q  = pw'(din) * pw'(fsin_i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      prod_i    <= '0;
      prod_q    <= '0;
      prod_vld  <= 1'b0;
      prod_last <= 1'b0;
    end else if (clken) begin
      prod_vld <= accept;
      if (accept) begin
        prod_i    <= mul_i;
        prod_q    <= -mul_q;
        prod_last <= (cnt == {lnd{1'b1}});
        cnt       <= cnt + lnd'(1);
      end
    end
  end

  // ---------------- stage 2: integrate and dump ----------------
  logic signed [aw-1:0] acc_i, acc_q, dump_i, dump_q, sum_i, sum_q;

  assign sum_i = acc_i + aw'(prod_i);
  assign sum_q = acc_q + aw'(prod_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_i     <= '0;
      acc_q     <= '0;
      dump_i    <= '0;
      dump_q    <= '0;
      sym_valid <= 1'b0;
    end else if (clken) begin
      sym_valid <= prod_vld & prod_last;
      if (prod_vld) begin
        if (prod_last) begin
          dump_i <= sum_i;
          dump_q <= sum_q;
          acc_i  <= '0;
          acc_q  <= '0;
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
        end
      end
    end
  end

  assign i_sym   = dump_i[aw-1:lnd];
  assign sym_bit = dump_i[aw-1];

  // ---------------- stage 3: Costas error and lock ----------------
  logic signed [pw-1:0]  q_sh, q_neg, err;
  logic signed [aw+2:0]  i_ext, q_ext, i_abs, q_abs;
  logic                  good;
  logic signed [apr-1:0] e_reg;
  logic                  e_vld;

  // The most-negative scaled Q has no positive twin; pin it to max.
  assign q_sh  = dump_q[aw-1:lnd];
  assign q_neg = (q_sh == {1'b1, {(pw-1){1'b0}}}) ? {1'b0, {(pw-1){1'b1}}} : -q_sh;
  assign err   = dump_i[aw-1] ? q_neg : q_sh;

  // Three guard bits so |x| and 2*|Q| never overflow the compare.
  assign i_ext = (aw+3)'(dump_i);
  assign q_ext = (aw+3)'(dump_q);
  assign i_abs = i_ext[aw+2] ? -i_ext : i_ext;
  assign q_abs = q_ext[aw+2] ? -q_ext : q_ext;
  assign good  = i_abs > (q_abs <<< 1);

  typedef enum logic {ACQ, TRACK} lock_state_t;
  lock_state_t   state, state_nx;
  logic [rw-1:0] run, run_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_reg <= '0;
      e_vld <= 1'b0;
      state <= ACQ;
      run   <= '0;
    end else if (clken) begin
      e_vld <= sym_valid;
      if (sym_valid) e_reg <= apr'(err);
      state <= state_nx;
      run   <= run_nx;
    end
  end

  always_comb begin
    state_nx = state;
    run_nx   = run;
    if (sym_valid) begin
      unique case (state)
        ACQ: begin
          if (good) begin
            if (run == rw'(lock_cnt - 1)) begin
              state_nx = TRACK;
              run_nx   = '0;
            end else begin
              run_nx = run + rw'(1);
            end
          end else begin
            run_nx = '0;
          end
        end
        TRACK: begin
          if (!good) begin
            if (run == rw'(lock_cnt - 1)) begin
              state_nx = ACQ;
              run_nx   = '0;
            end else begin
              run_nx = run + rw'(1);
            end
          end else begin
            run_nx = '0;
          end
        end
        default: begin
          state_nx = ACQ;
          run_nx   = '0;
        end
      endcase
    end
  end

  assign locked = (state == TRACK);

  // ---------------- stage 4: PI loop filter ----------------
  logic signed [apr-1:0] integ, integ_nx, e_ki, e_kp;
  logic signed [apr:0]   integ_sum;
  logic [apr-1:0]        phi_nx;

  assign e_ki      = e_reg >>> ki_sh;
  assign e_kp      = e_reg >>> kp_sh;
  assign integ_sum = (apr+1)'(integ) + (apr+1)'(e_ki);

  always_comb begin
    if (integ_sum > lim_pos)      integ_nx = lim_pos[apr-1:0];
    else if (integ_sum < lim_neg) integ_nx = lim_neg[apr-1:0];
    else                          integ_nx = integ_sum[apr-1:0];
  end

  assign phi_nx = phi_nom + integ_nx + e_kp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      integ         <= '0;
      phi_inc_o     <= phi_nom;
      phi_inc_valid <= 1'b0;
    end else if (clken) begin
      phi_inc_valid <= e_vld;
      if (e_vld) begin
        integ     <= integ_nx;
        phi_inc_o <= phi_nx;
      end
    end
  end

endmodule

// File: tb/tb_bpsk_costas_loop.sv
module tb_bpsk_costas_loop;

  localparam int          INTLIM  = 1000;
  localparam logic [31:0] PHI_NOM = 32'h0800_0000;

  logic              clk = 1'b0;
  logic              reset, clken, din_valid, nco_valid;
  logic signed [9:0] din, fsin_i, fcos_i;
  logic [31:0]       phi_inc_o;
  logic              phi_inc_valid, sym_bit, sym_valid, locked;
  logic signed [19:0] i_sym;

  bpsk_costas_loop #(.intlim(INTLIM)) dut (
    .clk(clk), .reset(reset), .clken(clken),
    .din(din), .din_valid(din_valid),
    .fsin_i(fsin_i), .fcos_i(fcos_i), .nco_valid(nco_valid),
    .phi_inc_o(phi_inc_o), .phi_inc_valid(phi_inc_valid),
    .i_sym(i_sym), .sym_bit(sym_bit), .sym_valid(sym_valid), .locked(locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ecyc = 0;   // count of enabled clock edges out of reset

  always @(posedge clk) if (!reset && clken) ecyc <= ecyc + 1;

  typedef struct { int i_sym; bit sbit; bit lk; int cyc; } sym_exp_t;
  typedef struct { logic [31:0] phi; bit lk; int cyc; } phi_exp_t;
  sym_exp_t sym_q[$];
  phi_exp_t phi_q[$];
  sym_exp_t sym_e;
  phi_exp_t phi_e;

  // reference model state
  int m_integ = 0;
  bit m_locked = 0;
  int m_run = 0;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called while the last sample of a symbol is being presented.
  task automatic model_symbol(int d, int c, int s);
    int idump, qdump, qs, e, isum, ai, aq;
    bit good;
    sym_exp_t se;
    phi_exp_t pe;
    idump = 16 * d * c;
    qdump = -16 * d * s;
    qs = qdump >>> 4;
    e = (idump >= 0) ? qs : -qs;
    se.i_sym = idump >>> 4;
    se.sbit  = (idump < 0);
    se.lk    = m_locked;
    se.cyc   = ecyc + 2;
    sym_q.push_back(se);
    ai = (idump < 0) ? -idump : idump;
    aq = (qdump < 0) ? -qdump : qdump;
    good = ai > 2 * aq;
    if (!m_locked) begin
      if (good) begin
        m_run++;
        if (m_run == 4) begin m_locked = 1; m_run = 0; end
      end else m_run = 0;
    end else begin
      if (!good) begin
        m_run++;
        if (m_run == 4) begin m_locked = 0; m_run = 0; end
      end else m_run = 0;
    end
    isum = m_integ + (e >>> 12);
    if (isum > INTLIM) isum = INTLIM;
    else if (isum < -INTLIM) isum = -INTLIM;
    m_integ = isum;
    pe.phi = PHI_NOM + 32'(m_integ) + 32'(e >>> 6);
    pe.lk  = m_locked;
    pe.cyc = ecyc + 4;
    phi_q.push_back(pe);
  endtask

  task automatic idle();
    clken = 1; din_valid = 0; nco_valid = 0; din = 0; fcos_i = 0; fsin_i = 0;
  endtask

  // One symbol of constant stimulus; gated adds nco_valid / clken holes
  // inside the symbol and a clken hole right after the last sample.
  task automatic send_sym(int d, int c, int s, bit gated);
    for (int k = 0; k < 16; k++) begin
      if (gated && k == 5) begin
        clken = 1; din_valid = 1; nco_valid = 0; din = 100; fcos_i = 300; fsin_i = 300;
        repeat (5) tick();
      end
      if (gated && k == 10) begin
        clken = 0; din_valid = 1; nco_valid = 1; din = -100; fcos_i = 200; fsin_i = -200;
        repeat (3) tick();
      end
      clken = 1; din_valid = 1; nco_valid = 1;
      din = 10'(d); fcos_i = 10'(c); fsin_i = 10'(s);
      if (k == 15) model_symbol(d, c, s);
      tick();
    end
    if (gated) begin
      clken = 0; din_valid = 0; nco_valid = 0;
      repeat (3) tick();
      clken = 1;
    end
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while ((sym_q.size() != 0 || phi_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sym_q.size() + phi_q.size());
    end
  endtask

  // monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (!reset && clken) begin
      if (sym_valid) begin
        if (sym_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sym_unexpected: got sym_valid=1 expected 0");
        end else begin
          sym_e = sym_q.pop_front();
          check("i_sym", i_sym, sym_e.i_sym);
          check("sym_bit", sym_bit, sym_e.sbit);
          check("locked_at_sym", locked, sym_e.lk);
          check("sym_latency", ecyc, sym_e.cyc);
        end
      end
      if (phi_inc_valid) begin
        if (phi_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL phi_unexpected: got phi_inc_valid=1 expected 0");
        end else begin
          phi_e = phi_q.pop_front();
          check("phi_inc_o", phi_inc_o, phi_e.phi);
          check("locked_at_phi", locked, phi_e.lk);
          check("phi_latency", ecyc, phi_e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_phi", phi_inc_o, PHI_NOM);
    check("rst_locked", locked, 0);
    check("rst_sym_valid", sym_valid, 0);
    check("rst_phi_valid", phi_inc_valid, 0);
    check("rst_i_sym", i_sym, 0);
    check("rst_sym_bit", sym_bit, 0);
    reset = 0;
    tick();

    // in-phase symbols: lock acquires on the 4th
    for (int n = 0; n < 4; n++) send_sym(256, 511, 0, 0);
    // silence: lock drops on the 4th
    for (int n = 0; n < 4; n++) send_sym(0, 511, 0, 0);
    // quadrature error: integ 31 then 62
    for (int n = 0; n < 2; n++) send_sym(256, 0, -511, 0);
    // negative I with a Q component: error sign flips, re-locks
    for (int n = 0; n < 4; n++) send_sym(-256, 511, -100, 0);
    drain();

    // partial symbol then asynchronous reset mid-cycle
    for (int k = 0; k < 7; k++) begin
      clken = 1; din_valid = 1; nco_valid = 1; din = 256; fcos_i = 511; fsin_i = 0;
      tick();
    end
    #2;
    reset = 1;
    #1;
    check("mid_rst_phi", phi_inc_o, PHI_NOM);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_sym_valid", sym_valid, 0);
    check("mid_rst_phi_valid", phi_inc_valid, 0);
    idle();
    m_integ = 0; m_locked = 0; m_run = 0;
    sym_q.delete();
    phi_q.delete();
    @(negedge clk);
    reset = 0;
    tick();

    // gated symbol after reset: full 16 accepted samples needed
    send_sym(256, 0, -511, 1);
    drain();

    // integrator saturation upward then downward
    for (int n = 0; n < 35; n++) send_sym(256, 0, -511, 0);
    for (int n = 0; n < 66; n++) send_sym(256, 0, 511, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
